// File: rtl/ins_pkg.sv
// Shared definitions for the instruction fetch queue: RV32 opcodes and the decoded field bundle.
package ins_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [4:0]  A1;
        logic [4:0]  A2;
        logic [4:0]  A3;
        logic [6:0]  OP;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] Imm;
    } ins_fields_t;

endpackage

// File: rtl/ins_field_split.sv
// Combinational split of an RV32 word into register/opcode fields and an immediate.
// IMM_GEN_EN selects full sign-extended immediate generation; otherwise Imm is the raw ins[31:7].
module ins_field_split
    import ins_pkg::*;
(
    input  logic [31:0] ins,
    output ins_fields_t fields
);

    always_comb begin
        fields.A1     = ins[19:15];
        fields.A2     = ins[24:20];
        fields.A3     = ins[11:7];
        fields.OP     = ins[6:0];
        fields.funct3 = ins[14:12];
        fields.funct7 = ins[31:25];
`ifdef IMM_GEN_EN
        case (ins[6:0])
            OP_ITYPE, OP_LOAD, OP_JALR: fields.Imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                   fields.Imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                  fields.Imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           fields.Imm = {ins[31:12], 12'b0};
            OP_JAL:                     fields.Imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                    fields.Imm = 32'b0;
        endcase
`else
        fields.Imm = {7'b0, ins[31:7]};
`endif
    end

endmodule

// File: rtl/ins_fetch_queue.sv
// DEPTH-entry instruction fetch FIFO with flush; head entry is presented pre-split into fields.
// Optional macro IMM_GEN_EN (in ins_field_split) enables sign-extended immediate generation.
module ins_fetch_queue
    import ins_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      A1,
    output logic [4:0]      A2,
    output logic [4:0]      A3,
    output logic [6:0]      OP,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [31:0]     Imm
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     ins_mem [DEPTH];
    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic            full, empty, push, pop;
    logic [31:0]     head_ins;
    ins_fields_t     head_fields;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // ready/valid come only from registered count, and flush suppresses both transfers.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= in_ins;
            pc_mem[wr_ptr]  <= in_pc;
        end
    end

    // An all-zero word decodes to all-zero fields, so gating the head word zeroes every output.
    assign head_ins = empty ? 32'b0 : ins_mem[rd_ptr];
    assign out_pc   = empty ? '0 : pc_mem[rd_ptr];

    ins_field_split u_split (
        .ins    (head_ins),
        .fields (head_fields)
    );

    assign A1     = head_fields.A1;
    assign A2     = head_fields.A2;
    assign A3     = head_fields.A3;
    assign OP     = head_fields.OP;
    assign funct3 = head_fields.funct3;
    assign funct7 = head_fields.funct7;
    assign Imm    = head_fields.Imm;

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: directed table, corner sequences and random traffic vs a queue model.
module tb_ins_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_ins, in_pc, out_pc, Imm;
  logic [4:0]  A1, A2, A3;
  logic [6:0]  OP, funct7;
  logic [2:0]  funct3;

  ins_fetch_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .A1(A1), .A2(A2), .A3(A3), .OP(OP), .funct3(funct3), .funct7(funct7), .Imm(Imm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];  // {pc, ins}, head at index 0

  typedef struct {
    logic fl, iv, ordy;
    logic [31:0] pc;
    logic ev, er;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = v;
    if (v[bits-1]) r = v | (32'hFFFF_FFFF << bits);
    return r;
  endfunction

  // Reference immediate: assemble the offset as an integer, then sign extend.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
`ifdef IMM_GEN_EN
    logic [31:0] v;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: v = sx(32'(w >> 20), 12);
      7'h23: v = sx((32'(w >> 25) << 5) + 32'((w >> 7) & 32'h1F), 12);
      7'h63: v = sx((32'(w[31]) << 12) + (32'(w[7]) << 11) + (32'((w >> 25) & 32'h3F) << 5)
                    + (32'((w >> 8) & 32'hF) << 1), 13);
      7'h37, 7'h17: v = w & 32'hFFFF_F000;
      7'h6F: v = sx((32'(w[31]) << 20) + (32'((w >> 12) & 32'hFF) << 12) + (32'(w[20]) << 11)
                    + (32'((w >> 21) & 32'h3FF) << 1), 21);
      default: v = 0;
    endcase
    return v;
`else
    return w >> 7;
`endif
  endfunction

  task automatic chk_outputs(input string tag);
    logic [31:0] w, p;
    w = (exp_q.size() > 0) ? exp_q[0][31:0] : 32'h0;
    p = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk({tag, ".out_pc"}, out_pc, p);
    chk({tag, ".A1"}, 32'(A1), (w >> 15) & 32'h1F);
    chk({tag, ".A2"}, 32'(A2), (w >> 20) & 32'h1F);
    chk({tag, ".A3"}, 32'(A3), (w >> 7) & 32'h1F);
    chk({tag, ".OP"}, 32'(OP), w & 32'h7F);
    chk({tag, ".funct3"}, 32'(funct3), (w >> 12) & 32'h7);
    chk({tag, ".funct7"}, 32'(funct7), w >> 25);
    chk({tag, ".Imm"}, Imm, ref_imm(w));
  endtask

  // Driver: called at a falling edge; applies inputs, checks, advances one clock, updates model.
  task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy, input string tag);
    bit do_push, do_pop;
    flush = fl; in_valid = iv; in_ins = ins; in_pc = pc; out_ready = ordy;
    #1;
    chk_outputs(tag);
    do_push = iv && (exp_q.size() < DEPTH) && !fl;
    do_pop  = (exp_q.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, ins});
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic fl, iv, ordy, input logic [31:0] pc,
                              input logic ev, er, input logic [31:0] epc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ev = ev; v.er = er; v.epc = epc;
    return v;
  endfunction

  initial begin
    logic [31:0] r, w;
    logic [6:0]  ops[10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};

    // Fill then overflow-attempt, full-queue streaming across wrap, then flush.
    tbl[0]  = mk(0, 1, 0, 32'h100, 1, 1, 32'h100);
    tbl[1]  = mk(0, 1, 0, 32'h104, 1, 1, 32'h100);
    tbl[2]  = mk(0, 1, 0, 32'h108, 1, 1, 32'h100);
    tbl[3]  = mk(0, 1, 0, 32'h10C, 1, 0, 32'h100);
    tbl[4]  = mk(0, 1, 0, 32'h110, 1, 0, 32'h100);
    tbl[5]  = mk(0, 1, 1, 32'h110, 1, 1, 32'h104);
    tbl[6]  = mk(0, 1, 1, 32'h110, 1, 1, 32'h108);
    tbl[7]  = mk(0, 1, 1, 32'h114, 1, 1, 32'h10C);
    tbl[8]  = mk(0, 1, 1, 32'h118, 1, 1, 32'h110);
    tbl[9]  = mk(0, 1, 1, 32'h11C, 1, 1, 32'h114);
    tbl[10] = mk(0, 1, 1, 32'h120, 1, 1, 32'h118);
    tbl[11] = mk(0, 1, 1, 32'h124, 1, 1, 32'h11C);
    tbl[12] = mk(0, 1, 1, 32'h128, 1, 1, 32'h120);
    tbl[13] = mk(1, 1, 1, 32'h12C, 0, 1, 32'h0);

    // Reset block
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_ins = 0; in_pc = 0;
    repeat (2) @(negedge clk);
    chk_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    // addi x5,x6,10 at PC 0x100
    step(0, 1, 32'h00A30293, 32'h100, 0, "t1.push");
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    chk("t1.A1", 32'(A1), 32'd6);
    chk("t1.A3", 32'(A3), 32'd5);
    chk("t1.OP", 32'(OP), 32'h13);
    chk("t1.funct3", 32'(funct3), 32'd0);
    chk("t1.out_pc", out_pc, 32'h100);
`ifdef IMM_GEN_EN
    chk("t1.Imm", Imm, 32'd10);
`else
    chk("t1.Imm", Imm, 32'h0014605);
`endif
    step(1, 0, 32'h0, 32'h0, 0, "t1.flush");

    for (int i = 0; i < 14; i++) begin
      w = 32'h00A30293 + (tbl[i].pc << 20);
      step(tbl[i].fl, tbl[i].iv, w, tbl[i].pc, tbl[i].ordy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.out_pc", i), out_pc, tbl[i].epc);
    end
    chk("t4.Imm_zero", Imm, 32'h0);
    chk("t4.OP_zero", 32'(OP), 32'h0);

`ifdef IMM_GEN_EN
    step(0, 1, 32'hFE000EE3, 32'h200, 0, "t5.beq");
    chk("t5.beq_imm", Imm, ref_imm(32'hFE000EE3));
    step(0, 1, 32'h123452B7, 32'h204, 1, "t5.lui");
    chk("t5.lui_imm", Imm, 32'h12345000);
    step(1, 0, 32'h0, 32'h0, 0, "t5.flush");
`endif

    // Asynchronous reset with two entries queued
    step(0, 1, 32'h00A30293, 32'h300, 0, "t6.p0");
    step(0, 1, 32'h00B30313, 32'h304, 0, "t6.p1");
    in_valid = 1; in_ins = 32'h00C30393; in_pc = 32'h308;
    #2 rst_n = 0;
    #1;
    exp_q.delete();
    chk("t6.async_out_valid", 32'(out_valid), 32'd0);
    chk("t6.async_in_ready", 32'(in_ready), 32'd1);
    chk("t6.async_out_pc", out_pc, 32'h0);
    chk("t6.async_A1", 32'(A1), 32'h0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 32'h0, 32'h0, 1, "t6.after");
    chk("t6.after_out_valid", 32'(out_valid), 32'd0);
    chk("t6.after_in_ready", 32'(in_ready), 32'd1);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      w = {r[31:7], ops[$urandom_range(0, 9)]};
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, w,
           32'($urandom()) & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0, "rnd");
    end
    chk_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
